// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : read_arbiter
//  Purpose  : Per-image-group read arbiter. Picks one eligible read port per
//             cycle (round-robin, gated by each port's nostall level), issues
//             the request to the group's memory banks one cycle later, and
//             routes the memory return back to the issuing port with a
//             one-hot valid, MEM_LATENCY+2 cycles after acceptance.
//  Optional : define READ_ARB_STAT_EN to add grant/stall statistic counters.
//
//  Ports    :
//    clk, rst_n            clock, asynchronous active-low reset
//    read_en_i             per-port request
//    read_bank_en_i        per-port bank enables  (port p at [p*ROW_PARA +: ROW_PARA])
//    read_addr_i           per-port address       (port p at [p*ADDR_WIDTH +: ADDR_WIDTH])
//    read_addr_ready_o     one-hot grant (combinational)
//    read_nostall_i        port may be granted only when high
//    read_data_valid_o     one-hot return valid
//    read_data_o           return data, shared by all ports
//    mem_rd_en_o           memory read strobe
//    mem_bank_en_o         memory bank enables
//    mem_addr_o            memory address (low bits of request address)
//    mem_rd_data_i         memory read data, MEM_LATENCY cycles after strobe
//    stat_grant_cnt_o      (READ_ARB_STAT_EN) per-port accept counters, 32 bits each
//    stat_stall_cnt_o      (READ_ARB_STAT_EN) cycles with a request blocked by nostall
//
//  Revision : 1.0  initial release
// ============================================================================
module read_arbiter #(
   parameter int PORT_NUM       = 3,
   parameter int ROW_PARA       = 4,
   parameter int ADDR_WIDTH     = 48,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 256,
   parameter int MEM_LATENCY    = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [PORT_NUM-1:0]            read_en_i,
   input  logic [PORT_NUM*ROW_PARA-1:0]   read_bank_en_i,
   input  logic [PORT_NUM*ADDR_WIDTH-1:0] read_addr_i,
   output logic [PORT_NUM-1:0]            read_addr_ready_o,
   input  logic [PORT_NUM-1:0]            read_nostall_i,
   output logic [PORT_NUM-1:0]            read_data_valid_o,
   output logic [DATA_WIDTH-1:0]          read_data_o,
   output logic                           mem_rd_en_o,
   output logic [ROW_PARA-1:0]            mem_bank_en_o,
   output logic [MEM_ADDR_WIDTH-1:0]      mem_addr_o,
   input  logic [DATA_WIDTH-1:0]          mem_rd_data_i
`ifdef READ_ARB_STAT_EN
   ,
   output logic [PORT_NUM*32-1:0]         stat_grant_cnt_o,
   output logic [31:0]                    stat_stall_cnt_o
`endif
);

   localparam int PTR_W     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int TAG_DEPTH = MEM_LATENCY + 1;

   logic [PORT_NUM-1:0]       eligible;
   logic [PORT_NUM-1:0]       grant;
   logic                      accept;
   logic [PTR_W-1:0]          ptr;
   logic [PTR_W-1:0]          ptr_next;
   logic [ROW_PARA-1:0]       sel_bank;
   logic [MEM_ADDR_WIDTH-1:0] sel_addr;
   logic [PORT_NUM-1:0]       tag_pipe [TAG_DEPTH];

   assign eligible = read_en_i & read_nostall_i;

   // Round-robin search starting at ptr. The selected port's bank enable and
   // low address bits are muxed in the same pass.
   always_comb begin
      int  idx;
      int  nxt;
      logic found;
      grant    = '0;
      ptr_next = ptr;
      sel_bank = '0;
      sel_addr = '0;
      found    = 1'b0;
      idx      = 0;
      nxt      = 0;
      for (int i = 0; i < PORT_NUM; i++) begin
         idx = int'(ptr) + i;
         if (idx >= PORT_NUM) idx = idx - PORT_NUM;
         if (!found && eligible[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            nxt        = (idx + 1 == PORT_NUM) ? 0 : idx + 1;
            ptr_next   = PTR_W'(nxt);
            sel_bank   = read_bank_en_i[idx*ROW_PARA +: ROW_PARA];
            sel_addr   = read_addr_i[idx*ADDR_WIDTH +: MEM_ADDR_WIDTH];
         end
      end
      // No grant may be visible to the ports while the block is held in reset.
      if (!rst_n) grant = '0;
   end

   assign accept            = |grant;
   assign read_addr_ready_o = grant;

   generate
      if (PORT_NUM == 1) begin : g_ptr_const
         assign ptr = '0;
      end else begin : g_ptr_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ptr <= '0;
            end else if (accept) begin
               ptr <= ptr_next;
            end
         end
      end
   endgenerate

   // Issue stage: bank enable and address hold their last value when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en_o   <= 1'b0;
         mem_bank_en_o <= '0;
         mem_addr_o    <= '0;
      end else begin
         mem_rd_en_o <= accept;
         if (accept) begin
            mem_bank_en_o <= sel_bank;
            mem_addr_o    <= sel_addr;
         end
      end
   end

   // One-hot port tag travelling alongside each read; stage 0 lines up with
   // the memory strobe, the last stage with mem_rd_data_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAG_DEPTH; k++) tag_pipe[k] <= '0;
      end else begin
         tag_pipe[0] <= grant;
         for (int k = 1; k < TAG_DEPTH; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   // Return stage: data is captured only when a tagged read lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_valid_o <= '0;
         read_data_o       <= '0;
      end else begin
         read_data_valid_o <= tag_pipe[TAG_DEPTH-1];
         if (|tag_pipe[TAG_DEPTH-1]) begin
            read_data_o <= mem_rd_data_i;
         end
      end
   end

`ifdef READ_ARB_STAT_EN
   logic [31:0] grant_cnt [PORT_NUM];
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < PORT_NUM; p++) grant_cnt[p] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            if (grant[p] && (grant_cnt[p] != '1)) grant_cnt[p] <= grant_cnt[p] + 32'd1;
         end
         if ((|(read_en_i & ~read_nostall_i)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   generate
      for (genvar p = 0; p < PORT_NUM; p++) begin : g_stat_out
         assign stat_grant_cnt_o[p*32 +: 32] = grant_cnt[p];
      end
   endgenerate
   assign stat_stall_cnt_o = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_read_arbiter
//  Purpose  : Self-checking bench for read_arbiter. A cycle-indexed model
//             (round-robin pick, scheduled one-hot returns, memory data
//             history) is compared against the DUT on every cycle, plus a
//             few hand-computed scenarios. Honours READ_ARB_STAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_read_arbiter;

   localparam int P   = 3;
   localparam int RP  = 4;
   localparam int AW  = 48;
   localparam int MAW = 12;
   localparam int DW  = 256;
   localparam int LAT = 3;
   localparam int RET = LAT + 2;

   logic            clk;
   logic            rst_n;
   logic [P-1:0]    read_en_i;
   logic [P*RP-1:0] read_bank_en_i;
   logic [P*AW-1:0] read_addr_i;
   logic [P-1:0]    read_addr_ready_o;
   logic [P-1:0]    read_nostall_i;
   logic [P-1:0]    read_data_valid_o;
   logic [DW-1:0]   read_data_o;
   logic            mem_rd_en_o;
   logic [RP-1:0]   mem_bank_en_o;
   logic [MAW-1:0]  mem_addr_o;
   logic [DW-1:0]   mem_rd_data_i;
`ifdef READ_ARB_STAT_EN
   logic [P*32-1:0] stat_grant_cnt_o;
   logic [31:0]     stat_stall_cnt_o;
`endif

   read_arbiter #(
      .PORT_NUM(P), .ROW_PARA(RP), .ADDR_WIDTH(AW),
      .MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .read_en_i         (read_en_i),
      .read_bank_en_i    (read_bank_en_i),
      .read_addr_i       (read_addr_i),
      .read_addr_ready_o (read_addr_ready_o),
      .read_nostall_i    (read_nostall_i),
      .read_data_valid_o (read_data_valid_o),
      .read_data_o       (read_data_o),
      .mem_rd_en_o       (mem_rd_en_o),
      .mem_bank_en_o     (mem_bank_en_o),
      .mem_addr_o        (mem_addr_o),
      .mem_rd_data_i     (mem_rd_data_i)
`ifdef READ_ARB_STAT_EN
      ,
      .stat_grant_cnt_o  (stat_grant_cnt_o),
      .stat_stall_cnt_o  (stat_stall_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model state ----------------
   int            m_ptr   = 0;
   logic          m_rd_en = 1'b0;
   logic [RP-1:0] m_bank  = '0;
   logic [MAW-1:0] m_addr = '0;
   bit   [P-1:0]  sched   [0:8191];   // expected one-hot valid, by cycle
   logic [DW-1:0] mem_hist[0:8191];   // memory data seen in each cycle
`ifdef READ_ARB_STAT_EN
   logic [31:0]   m_gcnt [P];
   logic [31:0]   m_scnt;
   initial begin
      for (int p = 0; p < P; p++) m_gcnt[p] = '0;
      m_scnt = '0;
   end
`endif

   // Compare process: inputs are stable between posedge+1 and the next posedge.
   always @(negedge clk) begin
      int           g;
      int           idx;
      logic [P-1:0] elig;
      logic [P-1:0] exp_ready;
      mem_hist[cyc] = mem_rd_data_i;
      if (!rst_n) begin
         check("rst_ready", DW'(read_addr_ready_o), '0);
         check("rst_valid", DW'(read_data_valid_o), '0);
         check("rst_data",  read_data_o, '0);
         check("rst_rd_en", DW'(mem_rd_en_o), '0);
         check("rst_bank",  DW'(mem_bank_en_o), '0);
         check("rst_addr",  DW'(mem_addr_o), '0);
         m_ptr = 0; m_rd_en = 1'b0; m_bank = '0; m_addr = '0;
         for (int k = cyc; k < cyc + 8; k++) sched[k] = '0;
`ifdef READ_ARB_STAT_EN
         for (int p = 0; p < P; p++) m_gcnt[p] = '0;
         m_scnt = '0;
         check("rst_stat_stall", DW'(stat_stall_cnt_o), '0);
`endif
      end else begin
         elig = read_en_i & read_nostall_i;
         g = -1;
         for (int i = 0; i < P; i++) begin
            idx = (m_ptr + i) % P;
            if (g < 0 && elig[idx]) g = idx;
         end
         exp_ready = (g >= 0) ? P'(1 << g) : '0;
         check("ready",  DW'(read_addr_ready_o), DW'(exp_ready));
         check("rd_en",  DW'(mem_rd_en_o), DW'(m_rd_en));
         check("bank",   DW'(mem_bank_en_o), DW'(m_bank));
         check("addr",   DW'(mem_addr_o), DW'(m_addr));
         check("valid",  DW'(read_data_valid_o), DW'(sched[cyc]));
         if (sched[cyc] != '0) check("data", read_data_o, mem_hist[cyc-1]);
`ifdef READ_ARB_STAT_EN
         for (int p = 0; p < P; p++) check("stat_grant", DW'(stat_grant_cnt_o[p*32 +: 32]), DW'(m_gcnt[p]));
         check("stat_stall", DW'(stat_stall_cnt_o), DW'(m_scnt));
         if (g >= 0 && m_gcnt[g] != '1) m_gcnt[g] = m_gcnt[g] + 1;
         if ((|(read_en_i & ~read_nostall_i)) && m_scnt != '1) m_scnt = m_scnt + 1;
`endif
         if (g >= 0) begin
            m_ptr   = (g + 1) % P;
            m_rd_en = 1'b1;
            m_bank  = read_bank_en_i[g*RP +: RP];
            m_addr  = read_addr_i[g*AW +: MAW];
            sched[cyc + RET] = exp_ready;
         end else begin
            m_rd_en = 1'b0;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      for (int w = 0; w < DW / 32; w++) mem_rd_data_i[w*32 +: 32] = $urandom;
   endtask

   task automatic rand_req();
      read_en_i      = P'($urandom);
      read_nostall_i = ($urandom_range(0, 3) == 0) ? P'($urandom) : '1;
      read_bank_en_i = (P*RP)'($urandom);
      for (int p = 0; p < P; p++) read_addr_i[p*AW +: AW] = {16'($urandom), $urandom};
   endtask

   initial begin
      rst_n = 1'b0;
      read_en_i = '0; read_nostall_i = '1; read_bank_en_i = '0; read_addr_i = '0;
      mem_rd_data_i = '0;
      repeat (3) step();
      rst_n = 1'b1;

      // Single read from port 0; upper address bits must be ignored.
      read_en_i = 3'b001;
      read_bank_en_i = 12'h00F;
      read_addr_i[0 +: AW] = 48'hABC0_0000_0010;
      #2 check("t1_ready", DW'(read_addr_ready_o), DW'(3'b001));
      step();
      read_en_i = '0;
      #2;
      check("t1_rd_en", DW'(mem_rd_en_o), DW'(1'b1));
      check("t1_addr",  DW'(mem_addr_o), DW'(12'h010));
      check("t1_bank",  DW'(mem_bank_en_o), DW'(4'hF));
      step(); step(); step();
      mem_rd_data_i = 256'hABCD;
      step();
      #2;
      check("t1_valid", DW'(read_data_valid_o), DW'(3'b001));
      check("t1_data",  read_data_o, 256'hABCD);
      step();

      // Port 1 blocked by nostall for 4 cycles, then wins (pointer sits at 1).
      read_en_i = 3'b011;
      read_nostall_i = 3'b101;
      for (int i = 0; i < 4; i++) begin
         #2 check("t2_ready_p0", DW'(read_addr_ready_o), DW'(3'b001));
         step();
      end
      read_nostall_i = 3'b111;
      #2 check("t2_ready_p1", DW'(read_addr_ready_o), DW'(3'b010));
      step();
      read_en_i = '0;
      repeat (8) step();

      // Randomized phase with a reset pulse and a saturated burst.
      for (int i = 0; i < 2000; i++) begin
         step();
         rand_req();
         if (i == 1000) rst_n = 1'b0;
         if (i == 1002) rst_n = 1'b1;
         if (i >= 1500 && i < 1530) begin
            read_en_i = '1;
            read_nostall_i = '1;
         end
      end
      step();
      read_en_i = '0;
      repeat (10) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
